// File: rtl/mcu0_mem_arbiter_pkg.sv
// Shared definitions for the MCU0 memory arbiter: FSM states, requester IDs and
// the round-robin successor helper.
package mcu0_mem_arbiter_pkg;

    localparam int AW_DEFAULT = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BYTE0 = 2'd1,
        BYTE1 = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic [1:0] REQ_F = 2'd0;
    localparam logic [1:0] REQ_D = 2'd1;
    localparam logic [1:0] REQ_H = 2'd2;

    // Successor in the F -> D -> H -> F ring; an invalid ID falls back to F.
    function automatic logic [1:0] next_id(input logic [1:0] id);
        logic [1:0] nxt;
        case (id)
            REQ_F:   nxt = REQ_D;
            REQ_D:   nxt = REQ_H;
            default: nxt = REQ_F;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mcu0_rr_pick3.sv
// Combinational three-way round-robin picker: searches from the requester after
// ptr and reports the first one asking.
module mcu0_rr_pick3
    import mcu0_mem_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] gnt_id,
    output logic       any
);

    logic [1:0] first;
    logic [1:0] second;
    logic [1:0] third;

    always_comb begin
        first  = next_id(ptr);
        second = next_id(first);
        third  = next_id(second);
        any    = |req;
        gnt_id = REQ_F;
        if (req[first])
            gnt_id = first;
        else if (req[second])
            gnt_id = second;
        else if (req[third])
            gnt_id = third;
    end

endmodule

// File: rtl/mcu0_mem_arbiter.sv
// Shares the byte-wide MCU0 memory between fetch, data and host requesters,
// splitting each big-endian 16-bit access into two byte cycles.
module mcu0_mem_arbiter
    import mcu0_mem_arbiter_pkg::*;
#(
    parameter int AW = AW_DEFAULT
)
(
    input  logic          clock,
    input  logic          reset_n,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [15:0]   d_wdata,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [15:0]   h_wdata,
    output logic          f_ack,
    output logic          d_ack,
    output logic          h_ack,
    output logic [15:0]   rdata,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [1:0]    ptr;
    logic [1:0]    grant;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [15:0]   wdata_q;
    logic [7:0]    hi_q;

    logic [1:0]    gnt_id;
    logic          any;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [15:0]   sel_wdata;

    mcu0_rr_pick3 u_pick (
        .req    ({h_req, d_req, f_req}),
        .ptr    (ptr),
        .gnt_id (gnt_id),
        .any    (any)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = f_addr;
        sel_wdata = '0;
        case (gnt_id)
            REQ_D: begin
                sel_we    = d_we;
                sel_addr  = d_addr;
                sel_wdata = d_wdata;
            end
            REQ_H: begin
                sel_we    = h_we;
                sel_addr  = h_addr;
                sel_wdata = h_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= IDLE;
            ptr     <= REQ_H;
            grant   <= REQ_F;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hi_q    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any) begin
                grant   <= gnt_id;
                ptr     <= gnt_id;
                we_q    <= sel_we;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
            if (state == BYTE1)
                hi_q <= mem_rdata;
        end
    end

    // Outputs are gated by reset_n so a reset landing mid-write stops the byte strobe at once.
    always_comb begin
        state_nxt = state;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        f_ack     = 1'b0;
        d_ack     = 1'b0;
        h_ack     = 1'b0;
        rdata     = '0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (any)
                    state_nxt = BYTE0;
            end
            BYTE0: begin
                state_nxt = BYTE1;
                busy      = 1'b1;
                mem_addr  = addr_q;
                mem_we    = we_q;
                mem_wdata = wdata_q[15:8];
            end
            BYTE1: begin
                state_nxt = DONE;
                busy      = 1'b1;
                mem_addr  = addr_q + {{(AW-1){1'b0}}, 1'b1};
                mem_we    = we_q;
                mem_wdata = wdata_q[7:0];
            end
            DONE: begin
                state_nxt = IDLE;
                busy      = 1'b1;
                rdata     = {hi_q, mem_rdata};
                f_ack     = (grant == REQ_F);
                d_ack     = (grant == REQ_D);
                h_ack     = (grant == REQ_H);
            end
            default: state_nxt = IDLE;
        endcase
        if (!reset_n) begin
            mem_addr  = '0;
            mem_we    = 1'b0;
            mem_wdata = '0;
            f_ack     = 1'b0;
            d_ack     = 1'b0;
            h_ack     = 1'b0;
            rdata     = '0;
            busy      = 1'b0;
        end
    end

endmodule

// File: tb/tb_mcu0_mem_arbiter.sv
// Directed bench for mcu0_mem_arbiter with a 4 KiB byte memory model whose
// contents start as the low byte of each address.
module tb_mcu0_mem_arbiter;

    logic        clock;
    logic        reset_n;
    logic        f_req;
    logic [11:0] f_addr;
    logic        d_req;
    logic        d_we;
    logic [11:0] d_addr;
    logic [15:0] d_wdata;
    logic        h_req;
    logic        h_we;
    logic [11:0] h_addr;
    logic [15:0] h_wdata;
    logic        f_ack;
    logic        d_ack;
    logic        h_ack;
    logic [15:0] rdata;
    logic        busy;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int errors = 0;
    int checks = 0;

    mcu0_mem_arbiter #(.AW(12)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .h_req     (h_req),
        .h_we      (h_we),
        .h_addr    (h_addr),
        .h_wdata   (h_wdata),
        .f_ack     (f_ack),
        .d_ack     (d_ack),
        .h_ack     (h_ack),
        .rdata     (rdata),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: preloaded on the first edge, registered read of the old contents.
    logic [7:0] mem [0:4095];
    logic       loaded = 1'b0;
    always @(posedge clock) begin
        if (!loaded) begin
            for (int i = 0; i < 4096; i++)
                mem[i] = i[7:0];
            loaded = 1'b1;
        end
        mem_rdata <= mem[mem_addr];
        if (mem_we)
            mem[mem_addr] = mem_wdata;
    end

    task automatic clear_inputs();
        f_req = 1'b0; f_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
    endtask

    // Issues one request from an IDLE negedge and waits for its ack; lat counts negedges.
    task automatic run_access(input int who, input logic we, input logic [11:0] a,
                              input logic [15:0] wd, output logic [15:0] rd,
                              output int lat, output int busy_cnt, output logic got);
        logic ack;
        got = 1'b0; lat = 0; busy_cnt = 0; rd = '0;
        case (who)
            0: begin f_req = 1'b1; f_addr = a; end
            1: begin d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; end
            default: begin h_req = 1'b1; h_we = we; h_addr = a; h_wdata = wd; end
        endcase
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            lat++;
            if (busy === 1'b1) busy_cnt++;
            ack = (who == 0) ? f_ack : (who == 1) ? d_ack : h_ack;
            if (ack === 1'b1) begin
                got = 1'b1;
                rd  = rdata;
            end
        end
        clear_inputs();
        @(negedge clock);
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        checks++;
        if ({f_ack, d_ack, h_ack} !== 3'b000) begin errors++; $display("[TB] FAIL reset_acks got=%b want=000", {f_ack, d_ack, h_ack}); end
        checks++;
        if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we got=%b want=0", mem_we); end
        checks++;
        if (mem_addr !== 12'h000) begin errors++; $display("[TB] FAIL reset_mem_addr got=%h want=000", mem_addr); end
        checks++;
        if (mem_wdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_mem_wdata got=%h want=00", mem_wdata); end
        checks++;
        if (rdata !== 16'h0000) begin errors++; $display("[TB] FAIL reset_rdata got=%h want=0000", rdata); end
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_fetch();
        logic [15:0] rd;
        int lat, bc;
        logic got;
        run_access(0, 1'b0, 12'h010, 16'h0000, rd, lat, bc, got);
        checks++;
        if (!got) begin errors++; $display("[TB] FAIL fetch_ack_timeout got=none want=f_ack"); end
        // Grant cycle is cycle 1, so the ack sits in cycle 4: three edges after the request.
        checks++;
        if (lat != 3) begin errors++; $display("[TB] FAIL fetch_latency got=%0d want=3", lat); end
        checks++;
        if (rd !== 16'h1011) begin errors++; $display("[TB] FAIL fetch_rdata got=%h want=1011", rd); end
        checks++;
        if (bc != 3) begin errors++; $display("[TB] FAIL fetch_busy_cycles got=%0d want=3", bc); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL fetch_busy_after got=%b want=0", busy); end
    endtask

    task automatic test_host_write();
        logic [15:0] rd;
        int lat, bc;
        logic got;
        run_access(2, 1'b1, 12'h020, 16'hBEEF, rd, lat, bc, got);
        checks++;
        if (!got) begin errors++; $display("[TB] FAIL hwrite_ack_timeout got=none want=h_ack"); end
        checks++;
        if (mem[12'h020] !== 8'hBE) begin errors++; $display("[TB] FAIL hwrite_byte0 got=%h want=be", mem[12'h020]); end
        checks++;
        if (mem[12'h021] !== 8'hEF) begin errors++; $display("[TB] FAIL hwrite_byte1 got=%h want=ef", mem[12'h021]); end
        run_access(1, 1'b0, 12'h020, 16'h0000, rd, lat, bc, got);
        checks++;
        if (!got || rd !== 16'hBEEF) begin errors++; $display("[TB] FAIL dread_back got=%h ack=%b want=beef", rd, got); end
    endtask

    function automatic logic [15:0] rr_expected(input int id);
        case (id)
            0:       return 16'h1011;
            1:       return 16'h2223;
            default: return 16'h3435;
        endcase
    endfunction

    task automatic test_round_robin();
        int n, last, id;
        clear_inputs();
        reset_n = 1'b0;
        f_req = 1'b1; f_addr = 12'h110;
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h222;
        h_req = 1'b1; h_we = 1'b0; h_addr = 12'h334;
        @(negedge clock);
        reset_n = 1'b1;
        n = 0; last = 0;
        for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
            @(negedge clock);
            if ((f_ack | d_ack | h_ack) === 1'b1) begin
                id = (f_ack === 1'b1) ? 0 : (d_ack === 1'b1) ? 1 : 2;
                checks++;
                if ($countones({h_ack, d_ack, f_ack}) != 1) begin errors++; $display("[TB] FAIL rr_onehot got=%b want=one-hot", {h_ack, d_ack, f_ack}); end
                checks++;
                if (id != n % 3) begin errors++; $display("[TB] FAIL rr_order idx=%0d got=%0d want=%0d", n, id, n % 3); end
                checks++;
                if (rdata !== rr_expected(id)) begin errors++; $display("[TB] FAIL rr_rdata idx=%0d got=%h want=%h", n, rdata, rr_expected(id)); end
                checks++;
                if (n == 0 && cyc != 2) begin errors++; $display("[TB] FAIL rr_first_ack got=%0d want=2", cyc); end
                else if (n > 0 && cyc - last != 4) begin errors++; $display("[TB] FAIL rr_spacing idx=%0d got=%0d want=4", n, cyc - last); end
                last = cyc;
                n++;
                if (n == 6) clear_inputs();
            end
        end
        checks++;
        if (n != 6) begin errors++; $display("[TB] FAIL rr_ack_count got=%0d want=6", n); end
        clear_inputs();
        @(negedge clock);
    endtask

    task automatic test_wrap();
        logic [15:0] rd;
        int lat, bc;
        logic got;
        run_access(1, 1'b1, 12'hFFF, 16'h1234, rd, lat, bc, got);
        checks++;
        if (mem[12'hFFF] !== 8'h12) begin errors++; $display("[TB] FAIL wrap_byte0 got=%h want=12", mem[12'hFFF]); end
        checks++;
        if (mem[12'h000] !== 8'h34) begin errors++; $display("[TB] FAIL wrap_byte1 got=%h want=34", mem[12'h000]); end
        run_access(1, 1'b0, 12'hFFF, 16'h0000, rd, lat, bc, got);
        checks++;
        if (!got || rd !== 16'h1234) begin errors++; $display("[TB] FAIL wrap_readback got=%h ack=%b want=1234", rd, got); end
    endtask

    task automatic test_reset_mid_write();
        clear_inputs();
        h_req = 1'b1; h_we = 1'b1; h_addr = 12'h040; h_wdata = 16'hA5C3;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 12'h041) begin errors++; $display("[TB] FAIL midreset_byte1 got=we%b addr%h want=we1 addr041", mem_we, mem_addr); end
        reset_n = 1'b0;
        h_req   = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL midreset_we got=%b want=0", mem_we); end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || h_ack !== 1'b0) begin errors++; $display("[TB] FAIL midreset_state got=busy%b ack%b want=busy0 ack0", busy, h_ack); end
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || h_ack !== 1'b0) begin errors++; $display("[TB] FAIL midreset_idle got=busy%b ack%b want=busy0 ack0", busy, h_ack); end
        checks++;
        if (mem[12'h040] !== 8'hA5) begin errors++; $display("[TB] FAIL midreset_byte0_mem got=%h want=a5", mem[12'h040]); end
        checks++;
        if (mem[12'h041] !== 8'h41) begin errors++; $display("[TB] FAIL midreset_byte1_mem got=%h want=41", mem[12'h041]); end
    endtask

    task automatic test_latched_inputs();
        int acks;
        clear_inputs();
        d_req = 1'b1; d_we = 1'b1; d_addr = 12'h080; d_wdata = 16'h1357;
        @(negedge clock);
        d_addr  = 12'h090;
        d_wdata = 16'hFFFF;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (d_ack === 1'b1) begin
                acks++;
                clear_inputs();
            end
        end
        checks++;
        if (acks != 1) begin errors++; $display("[TB] FAIL latch_ack_count got=%0d want=1", acks); end
        checks++;
        if (mem[12'h080] !== 8'h13 || mem[12'h081] !== 8'h57) begin errors++; $display("[TB] FAIL latch_data got=%h%h want=1357", mem[12'h080], mem[12'h081]); end
        checks++;
        if (mem[12'h090] !== 8'h90 || mem[12'h091] !== 8'h91) begin errors++; $display("[TB] FAIL latch_stray got=%h%h want=9091", mem[12'h090], mem[12'h091]); end
    endtask

    initial begin
        clear_inputs();
        reset_n = 1'b0;
        test_reset();
        test_fetch();
        test_host_write();
        test_round_robin();
        test_wrap();
        test_reset_mid_write();
        test_latched_inputs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
